// File: rtl/pll_pkg.sv
// pll_pkg: shared Canary PLL types plus divider arithmetic helpers for the frequency sequencer.
// Revision 1.0
package pll_pkg;

   typedef enum logic [1:0] {
      UNLOCKED     = 2'd0,
      FREQ_LOCKED  = 2'd1,
      PHASE_LOCKED = 2'd2
   } lock_state_t;

   typedef enum logic [1:0] {
      BRAKE_OFF     = 2'd0,
      BRAKE_ENGAGE  = 2'd1,
      BRAKE_HOLD    = 2'd2,
      BRAKE_RELEASE = 2'd3
   } brake_state_t;

   typedef enum logic [2:0] {
      ST_RESET_PLL  = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_IDLE       = 3'd2,
      ST_BRAKE_PRE  = 3'd3,
      ST_BRAKE_POST = 3'd4,
      ST_FAIL       = 3'd5
   } pll_seq_state_t;

   // Divider values are ints; widen by one bit so the difference never overflows.
   function automatic logic signed [32:0] divn_delta(input logic [31:0] tgt, input logic [31:0] cur);
      return $signed({tgt[31], tgt}) - $signed({cur[31], cur});
   endfunction

   function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt,
                                               input int step);
      logic signed [32:0] d;
      d = divn_delta(tgt, cur);
      if (d > 33'(step))
         return cur + 32'(step);
      else if (d < -33'(step))
         return cur - 32'(step);
      else
         return tgt;
   endfunction

endpackage

// File: rtl/pll_freq_seq_timer.sv
// seq_timer: loadable down-counter; expired is high on the last counted cycle (count <= 1).
// Revision 1.0
module seq_timer #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= INIT;
      else if (load)
         count <= value;
      else if (count != '0)
         count <= count - WIDTH'(1);
   end

   assign expired = (count <= WIDTH'(1));

endmodule

// File: rtl/pll_freq_seq.sv
// pll_freq_seq: Canary PLL divider-change sequencer; small locked steps use the brake, others re-reset the PLL.
// Optional macro PLL_FREQ_SEQ_RAMP_EN turns large locked steps into a ramp of brake steps. Revision 1.0
module pll_freq_seq
   import pll_pkg::*;
#(
   parameter int DEFAULT_DIVN = 32,
   parameter int MIN_DIVN     = 8,
   parameter int MAX_DIVN     = 255,
   parameter int SMALL_STEP   = 2,
   parameter int BRAKE_CYCLES = 16,
   parameter int RST_CYCLES   = 4,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int MAX_RETRY    = 2
) (
   input  logic        refclk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_divn,
   output logic        req_ready,
   output logic        req_nack,
   input  lock_state_t lock_state,
   output logic [31:0] divn,
   output logic        brake,
   output logic        pll_resetn,
   output logic        busy,
   output logic        done,
   output logic        err
);

   pll_seq_state_t     state;
   logic [31:0]        target;
   logic [31:0]        step_divn;
   logic [31:0]        retries;
   logic signed [32:0] delta;
   logic [32:0]        abs_delta;
   logic               accept, in_range, locked, same;
   logic               path_brake, go_brake, go_reset, go_equal, post_more;
   logic               t_load, t_expired;
   logic [31:0]        t_value;

   assign accept    = req_valid && req_ready;
   assign delta     = divn_delta(req_divn, divn);
   assign abs_delta = delta[32] ? -delta : delta;
   assign in_range  = ($signed(req_divn) >= MIN_DIVN) && ($signed(req_divn) <= MAX_DIVN);
   assign locked    = (lock_state == PHASE_LOCKED);
   assign same      = (delta == '0);
   assign step_divn = step_toward(divn, target, SMALL_STEP);

`ifdef PLL_FREQ_SEQ_RAMP_EN
   assign path_brake = locked;
   assign post_more  = (divn != target);
`else
   assign path_brake = locked && (abs_delta <= 33'(SMALL_STEP));
   assign post_more  = 1'b0;
`endif

   assign go_equal = accept && in_range && (state == ST_IDLE) && same;
   assign go_brake = accept && in_range && (state == ST_IDLE) && !same && path_brake;
   assign go_reset = accept && in_range && ((state == ST_FAIL) || (!same && !path_brake));

   // Timer reloads mirror the FSM transitions below; RST_CYCLES is the default load value.
   always_comb begin
      t_load  = 1'b0;
      t_value = 32'(RST_CYCLES);
      case (state)
         ST_RESET_PLL: if (t_expired) begin
            t_load  = 1'b1;
            t_value = 32'(LOCK_TIMEOUT);
         end
         ST_WAIT_LOCK: if (!locked && t_expired && (retries < 32'(MAX_RETRY))) t_load = 1'b1;
         ST_IDLE, ST_FAIL: begin
            if (go_brake) begin
               t_load  = 1'b1;
               t_value = 32'(BRAKE_CYCLES);
            end else if (go_reset) begin
               t_load = 1'b1;
            end
         end
         ST_BRAKE_PRE: if (t_expired) begin
            t_load  = 1'b1;
            t_value = 32'(BRAKE_CYCLES);
         end
         // Ramp steps spend one extra PRE cycle with brake low between steps.
         ST_BRAKE_POST: if (t_expired && post_more) begin
            t_load = 1'b1;
            if (locked) t_value = 32'(BRAKE_CYCLES + 1);
         end
         default: t_load = 1'b1;
      endcase
   end

   seq_timer #(.WIDTH(32), .INIT(32'(RST_CYCLES))) u_timer (
      .clk     (refclk),
      .rst     (reset),
      .load    (t_load),
      .value   (t_value),
      .expired (t_expired)
   );

   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         state      <= ST_RESET_PLL;
         divn       <= 32'(DEFAULT_DIVN);
         target     <= 32'(DEFAULT_DIVN);
         pll_resetn <= 1'b0;
         brake      <= 1'b0;
         req_ready  <= 1'b0;
         req_nack   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b1;
         retries    <= '0;
      end else begin
         req_nack <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_RESET_PLL: if (t_expired) begin
               state      <= ST_WAIT_LOCK;
               pll_resetn <= 1'b1;
            end
            ST_WAIT_LOCK: begin
               if (locked) begin
                  state     <= ST_IDLE;
                  done      <= 1'b1;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end else if (t_expired) begin
                  if (retries < 32'(MAX_RETRY)) begin
                     retries    <= retries + 32'd1;
                     state      <= ST_RESET_PLL;
                     pll_resetn <= 1'b0;
                  end else begin
                     state     <= ST_FAIL;
                     err       <= 1'b1;
                     req_ready <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
            end
            ST_IDLE, ST_FAIL: begin
               if (accept && !in_range) begin
                  req_nack <= 1'b1;
               end else if (go_equal) begin
                  done <= 1'b1;
               end else if (go_brake) begin
                  state     <= ST_BRAKE_PRE;
                  brake     <= 1'b1;
                  target    <= req_divn;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end else if (go_reset) begin
                  state      <= ST_RESET_PLL;
                  divn       <= req_divn;
                  target     <= req_divn;
                  retries    <= '0;
                  pll_resetn <= 1'b0;
                  err        <= 1'b0;
                  req_ready  <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            ST_BRAKE_PRE: begin
               brake <= 1'b1;
               if (t_expired) begin
                  divn  <= step_divn;
                  state <= ST_BRAKE_POST;
               end
            end
            ST_BRAKE_POST: if (t_expired) begin
               brake <= 1'b0;
               if (!post_more) begin
                  state     <= ST_IDLE;
                  done      <= 1'b1;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end else if (locked) begin
                  state <= ST_BRAKE_PRE;
               end else begin
                  state      <= ST_RESET_PLL;
                  divn       <= target;
                  retries    <= '0;
                  pll_resetn <= 1'b0;
               end
            end
            default: begin
               state      <= ST_RESET_PLL;
               pll_resetn <= 1'b0;
               brake      <= 1'b0;
               req_ready  <= 1'b0;
               busy       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_freq_seq.sv
// tb_pll_freq_seq: table-driven request vectors with a scoreboard, plus retry/abort corner sequences.
module tb_pll_freq_seq;
   import pll_pkg::*;

`ifdef PLL_FREQ_SEQ_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic        refclk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_divn = '0;
   lock_state_t lock_state = UNLOCKED;
   logic        req_ready, req_nack, brake, pll_resetn, busy, done, err;
   logic [31:0] divn;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lock_delay = 100;
   bit force_unlock = 1'b0;

   typedef struct {
      logic [31:0] req;
      bit          nack;
      logic [31:0] exp_divn;
      int          exp_brake;
      int          exp_resets;
   } vec_t;

   typedef struct {
      bit          nack;
      logic [31:0] divn;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[13];

   pll_freq_seq dut (
      .refclk     (refclk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_divn   (req_divn),
      .req_ready  (req_ready),
      .req_nack   (req_nack),
      .lock_state (lock_state),
      .divn       (divn),
      .brake      (brake),
      .pll_resetn (pll_resetn),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 refclk = ~refclk;

   // PLL model: unlocked while in reset, phase lock lock_delay cycles after release.
   initial begin
      int lock_cnt;
      lock_cnt = 0;
      forever begin
         @(posedge refclk);
         #1;
         if (!pll_resetn || force_unlock) begin
            lock_cnt   = 0;
            lock_state = UNLOCKED;
         end else if (lock_cnt < lock_delay) begin
            lock_cnt++;
            lock_state = FREQ_LOCKED;
         end else begin
            lock_state = PHASE_LOCKED;
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic [31:0] v);
      int n;
      n = 0;
      while (!req_ready && n < 20000) begin
         step();
         n++;
      end
      chk("ready before request", req_ready, 1);
      req_valid = 1'b1;
      req_divn  = v;
      step();
      req_valid = 1'b0;
      req_divn  = $urandom;
   endtask

   // Runs until done/req_nack, pops the scoreboard and compares; returns activity counters.
   task automatic wait_event(input string name, input logic [31:0] d0, input logic prev_in,
                             output int brk, output int rlow, output int falls, output int chg);
      int   n;
      logic prev_rn;
      exp_t e;
      brk = 0; rlow = 0; falls = 0; chg = -1; n = 0;
      prev_rn = prev_in;
      chk({name, " scoreboard entry"}, sb.size() > 0, 1);
      e = (sb.size() > 0) ? sb.pop_front() : '{1'b0, 32'd0};
      while (!(done || req_nack) && n < 20000) begin
         if (chg < 0 && divn !== d0) chg = brk;
         if (brake) brk++;
         if (!pll_resetn) rlow++;
         if (prev_rn && !pll_resetn) begin
            falls++;
            chk({name, " divn at reset fall"}, divn, e.divn);
         end
         prev_rn = pll_resetn;
         step();
         n++;
      end
      if (chg < 0 && divn !== d0) chg = brk;
      chk({name, " event seen"}, done || req_nack, 1);
      chk({name, " nack"}, req_nack, e.nack);
      chk({name, " done"}, done, !e.nack);
      chk({name, " divn"}, divn, e.divn);
      chk({name, " ready"}, req_ready, 1);
      step();
      chk({name, " single pulse"}, done || req_nack, 0);
   endtask

   initial begin
      int          brk, rlow, falls, chg, lowcnt, nf, n;
      int          ft[3];
      logic        prev;

      vecs[0]  = '{32'd34,         1'b0, 32'd34,  32,                 0};
      vecs[1]  = '{32'd64,         1'b0, 32'd64,  RAMP ? 480 : 0,     RAMP ? 0 : 1};
      vecs[2]  = '{32'd64,         1'b0, 32'd64,  0,                  0};
      vecs[3]  = '{32'd300,        1'b1, 32'd64,  0,                  0};
      vecs[4]  = '{32'd4,          1'b1, 32'd64,  0,                  0};
      vecs[5]  = '{32'd63,         1'b0, 32'd63,  32,                 0};
      vecs[6]  = '{32'd255,        1'b0, 32'd255, RAMP ? 3072 : 0,    RAMP ? 0 : 1};
      vecs[7]  = '{32'd256,        1'b1, 32'd255, 0,                  0};
      vecs[8]  = '{32'd8,          1'b0, 32'd8,   RAMP ? 3968 : 0,    RAMP ? 0 : 1};
      vecs[9]  = '{32'd7,          1'b1, 32'd8,   0,                  0};
      vecs[10] = '{32'd10,         1'b0, 32'd10,  32,                 0};
      vecs[11] = '{32'd13,         1'b0, 32'd13,  RAMP ? 64 : 0,      RAMP ? 0 : 1};
      vecs[12] = '{32'hFFFF_FFFB,  1'b1, 32'd13,  0,                  0};

      step();
      step();
      chk("reset divn", divn, 32);
      chk("reset pll_resetn", pll_resetn, 0);
      chk("reset brake", brake, 0);
      chk("reset req_ready", req_ready, 0);
      chk("reset req_nack", req_nack, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset busy", busy, 1);

      // Power-up: PLL reset pulse width, then lock after 100 cycles.
      reset  = 1'b0;
      lowcnt = 0;
      while (!pll_resetn && lowcnt < 100) begin
         lowcnt++;
         step();
      end
      chk("power-up reset width", lowcnt, 4);
      sb.push_back('{1'b0, 32'd32});
      wait_event("power-up", 32'd32, 1'b1, brk, rlow, falls, chg);
      chk("power-up brake", brk, 0);

      lock_delay = 10;
      for (int i = 0; i < 13; i++) begin
         logic [31:0] d0;
         int          exp_chg;
         d0 = divn;
         exp_chg = (vecs[i].exp_brake > 0) ? BRAKE_CYCLES_TB() : ((vecs[i].exp_resets > 0) ? 0 : -1);
         sb.push_back('{vecs[i].nack, vecs[i].exp_divn});
         drive_req(vecs[i].req);
         wait_event($sformatf("vec%0d", i), d0, 1'b1, brk, rlow, falls, chg);
         chk($sformatf("vec%0d brake cycles", i), brk, vecs[i].exp_brake);
         chk($sformatf("vec%0d reset pulses", i), falls, vecs[i].exp_resets);
         chk($sformatf("vec%0d reset low cycles", i), rlow, 4 * vecs[i].exp_resets);
         chk($sformatf("vec%0d divn change point", i), chg, exp_chg);
      end

      // Lock never arrives: three reset attempts spaced 4+4096 cycles, then the failed state.
      force_unlock = 1'b1;
      step();
      step();
      drive_req(32'd50);
      nf = 0; n = 0; prev = 1'b1;
      while (!err && n < 15000) begin
         if (prev && !pll_resetn) begin
            if (nf < 3) ft[nf] = cyc;
            nf++;
         end
         prev = pll_resetn;
         step();
         n++;
      end
      chk("retry reset pulses", nf, 3);
      chk("retry gap 1", ft[1] - ft[0], 4100);
      chk("retry gap 2", ft[2] - ft[1], 4100);
      chk("failed err", err, 1);
      chk("failed ready", req_ready, 1);
      chk("failed busy", busy, 0);
      force_unlock = 1'b0;
      sb.push_back('{1'b0, 32'd40});
      drive_req(32'd40);
      chk("recover err cleared", err, 0);
      chk("recover pll_resetn", pll_resetn, 0);
      chk("recover divn", divn, 40);
      wait_event("recover", 32'd40, 1'b0, brk, rlow, falls, chg);

      // Asynchronous reset in the middle of a brake step.
      drive_req(32'd42);
      repeat (5) step();
      chk("abort in brake", brake, 1);
      #3;
      reset = 1'b1;
      #1;
      chk("abort brake", brake, 0);
      chk("abort divn", divn, 32);
      chk("abort pll_resetn", pll_resetn, 0);
      chk("abort busy", busy, 1);
      @(posedge refclk);
      #1;
      reset = 1'b0;
      sb.push_back('{1'b0, 32'd32});
      wait_event("after abort", 32'd32, 1'b0, brk, rlow, falls, chg);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   function automatic int BRAKE_CYCLES_TB();
      return 16;
   endfunction

endmodule

// File: doc/pll_freq_seq.md
Name: pll_freq_seq

Overview:
Frequency-change sequencer for the Canary PLL, clocked on refclk. It owns the PLL's divn, brake and active-low resetn inputs and accepts divider-change requests over a valid/ready handshake. Small steps on a phase-locked PLL are applied under the droop-management brake. All other changes re-reset the PLL and wait for PHASE_LOCKED, because the PLL's lock detector locks only once. Lock-wait timeouts trigger bounded retries.

Parameters:
- DEFAULT_DIVN, 32: divn driven out of reset.
- MIN_DIVN, 8: smallest legal divn, inclusive.
- MAX_DIVN, 255: largest legal divn, inclusive.
- SMALL_STEP, 2: largest |delta| eligible for the brake path.
- BRAKE_CYCLES, 16: cycles brake is held before the divn update, and again after it.
- RST_CYCLES, 4: cycles pll_resetn is held low per PLL reset.
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry.
- MAX_RETRY, 2: retries after the first attempt before FAIL.

Ports:
- refclk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- req_valid, in, 1: change request.
- req_divn, in, 32 (int): requested divn.
- req_ready, out, 1: high in IDLE and FAIL only.
- req_nack, out, 1: one-cycle pulse when an out-of-range request is discarded.
- lock_state, in, lock_state_t: lock status from the PLL.
- divn, out, 32 (int): divider value to the PLL.
- brake, out, 1: brake request to the PLL.
- pll_resetn, out, 1: active-low reset to the PLL.
- busy, out, 1: high when the state is neither IDLE nor FAIL.
- done, out, 1: one-cycle pulse when a change completes.
- err, out, 1: sticky; high in FAIL.

Behaviour:
- All outputs are registered.
- Reset values: state=RESET_PLL, divn=DEFAULT_DIVN, pll_resetn=0, brake=0, req_ready=0, req_nack=0, done=0, err=0, busy=1, retry count=0, timer=RST_CYCLES.
- Reset asserted mid-operation aborts the current change immediately. Any in-flight request is lost.
- States: RESET_PLL, WAIT_LOCK, IDLE, BRAKE_PRE, BRAKE_POST, FAIL.
- RESET_PLL:
  - pll_resetn=0 for exactly RST_CYCLES cycles.
  - Then go to WAIT_LOCK with pll_resetn=1 and timer=LOCK_TIMEOUT.
- WAIT_LOCK, lock_state==PHASE_LOCKED: go to IDLE and pulse done on the same edge.
- WAIT_LOCK, timer expires:
  - If retries < MAX_RETRY: increment retries and go to RESET_PLL.
  - Otherwise: go to FAIL with err=1.
  - If PHASE_LOCKED arrives on the expiry cycle, lock wins.
- Handshake: a request is accepted on a cycle with req_valid && req_ready. req_divn is sampled only on that cycle.
- Accept with req_divn outside [MIN_DIVN, MAX_DIVN]: pulse req_nack next cycle. State and divn are unchanged.
- Accept with req_divn == divn: pulse done next cycle and stay in IDLE.
- Accept with 0 < |req_divn − divn| ≤ SMALL_STEP and lock_state==PHASE_LOCKED: brake path.
  - Go to BRAKE_PRE with brake=1.
  - After BRAKE_CYCLES cycles: divn ← target, go to BRAKE_POST.
  - After BRAKE_CYCLES more cycles: brake=0, go to IDLE, pulse done.
  - brake is therefore high for exactly 2·BRAKE_CYCLES cycles.
- Any other accepted in-range request: reset path.
  - divn ← target, retries ← 0, go to RESET_PLL.
  - divn changes on the same edge that pll_resetn falls.
- FAIL:
  - req_ready=1.
  - An accepted in-range request clears err and takes the reset path. This is also true when req_divn equals the current divn.
- Arithmetic: delta is computed in 33-bit signed to avoid overflow.

Optional Feature:
PLL_FREQ_SEQ_RAMP_EN
- Defined:
  - An in-range request with |delta| > SMALL_STEP on a PHASE_LOCKED PLL is executed as successive brake-path steps of SMALL_STEP toward the target. The last step is the remainder.
  - There is one BRAKE_PRE/BRAKE_POST pair per step; brake drops between steps.
  - done pulses only after the final step. No PLL reset occurs.
  - If lock_state leaves PHASE_LOCKED between steps, switch to the reset path toward the final target.
- Undefined: large steps use the reset path.

Decomposition:
- Package pll_pkg holds the existing lock_state_t and brake_state_t, plus a new pll_seq_state_t enum.
- One sub-module: seq_timer, a loadable down-counter with an expired flag. It is shared by RESET_PLL, WAIT_LOCK and the BRAKE states.

Test Plan:
1. Release reset; lock_state=PHASE_LOCKED arrives 100 cycles after pll_resetn rises -> pll_resetn low exactly 4 cycles; divn=32; done pulses once; req_ready=1.
2. In IDLE and locked, request 34 -> brake high exactly 32 cycles; divn changes 34 after 16 of them; done pulses on the cycle brake falls; pll_resetn stays 1.
3. Request 64 from 34 -> divn=64 and pll_resetn=0 on the same edge; relock then done; with PLL_FREQ_SEQ_RAMP_EN, 15 brake steps instead and no reset.
4. Hold lock_state=UNLOCKED -> 3 reset pulses spaced 4+4096 cycles apart, then FAIL with err=1; request 40 -> err clears and the reset path runs.
5. Request 300, then request 4 -> req_nack pulses each time; divn unchanged; no state change.
6. Assert reset during BRAKE_PRE -> brake=0, divn=32, pll_resetn=0 immediately (asynchronous).
